// File: rtl/prover_h_chi_seq_pkg.sv
// prover_h_chi_seq_pkg: field constants, FSM state encoding and sizing helper
// shared by the h_chi round sequencer and its one-minus helper.
`default_nettype none

package prover_h_chi_seq_pkg;

    localparam int F_NBITS = 64;
    // Goldilocks prime q = 2^64 - 2^32 + 1
    localparam logic [F_NBITS-1:0] F_Q       = 64'hFFFF_FFFF_0000_0001;
    // (2 - 2^F_NBITS) mod q, so that ~x + F_Q_P2_MI == 1 - x (mod q)
    localparam logic [F_NBITS-1:0] F_Q_P2_MI = 64'hFFFF_FFFE_0000_0004;
    localparam logic [F_NBITS-1:0] F_ONE     = {{(F_NBITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREP      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_IDLE = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    function automatic int round_w(input int npoints);
        return $clog2(npoints + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prover_tau_one_minus.sv
// prover_tau_one_minus: two-stage field add computing ~in + F_Q_P2_MI (= 1 - in mod q).
// o_ready pulses for one cycle when o_out holds the fully reduced result.
`default_nettype none

module prover_tau_one_minus
    import prover_h_chi_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               i_en,
    input  logic [F_NBITS-1:0] i_in,
    output logic               o_ready,
    output logic [F_NBITS-1:0] o_out
);

    logic [F_NBITS:0]   r_sum;
    logic               r_v1;
    logic [F_NBITS:0]   w_s1;
    logic [F_NBITS-1:0] w_s2;

    // Sum of two N-bit values is below 3q, so two conditional subtractions fully reduce it
    assign w_s1 = (r_sum >= {1'b0, F_Q}) ? (r_sum - {1'b0, F_Q}) : r_sum;
    assign w_s2 = (w_s1 >= {1'b0, F_Q}) ? (w_s1[F_NBITS-1:0] - F_Q) : w_s1[F_NBITS-1:0];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sum   <= '0;
            r_v1    <= 1'b0;
            o_ready <= 1'b0;
            o_out   <= '0;
        end else begin
            r_v1    <= i_en;
            o_ready <= r_v1;
            if (i_en) begin
                r_sum <= {1'b0, ~i_in} + {1'b0, F_Q_P2_MI};
            end
            if (r_v1) begin
                o_out <= w_s2;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prover_compute_h_chi_seq.sv
// prover_compute_h_chi_seq: issues NPOINTS tau rounds plus one accumulate round to the
// h_chi chain; define PROVER_H_CHI_SEQ_TIMEOUT_EN to add the NTIMEOUT watchdog and err flag.
`default_nettype none

module prover_compute_h_chi_seq
    import prover_h_chi_seq_pkg::*;
#(
    parameter int NPOINTS  = 5,
    parameter int NTIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       i_start,
    input  logic [NPOINTS*F_NBITS-1:0] i_tau_in,
    input  logic                       i_all_ready,
    output logic                       o_chi_en,
    output logic                       o_chi_restart,
    output logic [F_NBITS-1:0]         o_tau,
    output logic [F_NBITS-1:0]         o_m_tau_p1,
    output logic                       o_busy,
    output logic                       o_done_pulse,
    output logic                       o_err
);

    localparam int RW = round_w(NPOINTS);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NPOINTS);
    localparam logic [RW-1:0] LAST_TAU   = RW'(NPOINTS - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic [RW-1:0]              r_round;
    logic [NPOINTS*F_NBITS-1:0] r_tau_vec;
    logic [F_NBITS-1:0]         r_tau;
    logic [F_NBITS-1:0]         r_m;
    logic                       w_om_en;
    logic [F_NBITS-1:0]         w_om_in;
    logic                       w_om_ready;
    logic [F_NBITS-1:0]         w_om_out;
    logic                       w_timeout;
    logic                       w_waiting;

    prover_tau_one_minus u_one_minus (
        .clk     (clk),
        .rstb    (rstb),
        .i_en    (w_om_en),
        .i_in    (w_om_in),
        .o_ready (w_om_ready),
        .o_out   (w_om_out)
    );

    assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_IDLE);

    // one_minus is launched on the transition into PREP, so the head of r_tau_vec is the next tau
    always_comb begin
        w_next  = r_state;
        w_om_en = 1'b0;
        w_om_in = r_tau_vec[F_NBITS-1:0];
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next  = S_PREP;
                    w_om_en = 1'b1;
                    w_om_in = i_tau_in[F_NBITS-1:0];
                end
            end
            S_PREP: begin
                if ((r_round == LAST_ROUND) || w_om_ready) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (w_timeout) begin
                    w_next = S_DONE;
                end else if (!i_all_ready) begin
                    w_next = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (w_timeout) begin
                    w_next = S_DONE;
                end else if (i_all_ready) begin
                    if (r_round < LAST_ROUND) begin
                        w_next  = S_PREP;
                        w_om_en = (r_round < LAST_TAU);
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= S_IDLE;
            r_round   <= '0;
            r_tau_vec <= '0;
            r_tau     <= '0;
            r_m       <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && i_start) begin
                r_tau_vec <= i_tau_in >> F_NBITS;
                r_round   <= '0;
            end else if (w_om_en) begin
                r_tau_vec <= r_tau_vec >> F_NBITS;
            end
            if (w_om_en) begin
                r_tau <= w_om_in;
            end
            if (r_state == S_PREP) begin
                if (r_round == LAST_ROUND) begin
                    r_tau <= '0;
                    r_m   <= F_ONE;
                end else if (w_om_ready) begin
                    r_m <= w_om_out;
                end
            end
            if ((r_state == S_WAIT_IDLE) && i_all_ready && !w_timeout) begin
                r_round <= r_round + RW'(1);
            end
        end
    end

`ifdef PROVER_H_CHI_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(NTIMEOUT + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(NTIMEOUT - 1);

    logic [WW-1:0] r_wd;
    logic          r_err;

    assign w_timeout = w_waiting && (r_wd == WD_LIMIT);
    assign o_err     = r_err;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_waiting && (w_next == r_state)) begin
                r_wd <= r_wd + WW'(1);
            end else begin
                r_wd <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_ntimeout;

    assign w_unused_ntimeout = w_waiting & (NTIMEOUT > 0);
    assign w_timeout         = 1'b0;
    assign o_err             = 1'b0;
`endif

    assign o_chi_en      = (r_state == S_ISSUE);
    assign o_chi_restart = (r_state == S_ISSUE) && (r_round == '0);
    assign o_tau         = r_tau;
    assign o_m_tau_p1    = r_m;
    assign o_busy        = (r_state == S_PREP) || (r_state == S_ISSUE) || w_waiting;
    assign o_done_pulse  = (r_state == S_DONE);

endmodule

`default_nettype wire
